frame_loader: RTL and testbench



---
 rtl/frame_loader.sv | 214 +++++++++++++++++++++
 tb/tb_frame_loader.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/frame_loader.sv
// Purpose: double-buffered 24-bit pixel store; packs an R,G,B byte stream into the back bank and serves the front bank.
// Latency: a pixel is written 1 cycle after its B byte; rd_data is registered (1 cycle after rd_addr); banks swap on a vga_vs falling edge.
// Backpressure: s_ready is low only while a finished frame waits for vsync; otherwise one byte is accepted every cycle.
//
// Ports:
//   clk, reset          single clock, synchronous active-high reset
//   s_data/s_valid/     byte stream (R,G,B per pixel, raster order); s_sof marks the first byte of a frame
//   s_sof/s_ready
//   vga_vs              display vertical sync, active low; its falling edge releases a pending swap
//   rd_addr/rd_data     front-bank read port (row*COLS+col), out-of-range addresses read as 0
//   active_bank         bank currently shown as front
//   frame_done          pulse when the last pixel of the back frame is written
//   resync_err          pulse when s_sof arrives in the middle of a frame
//   frame_cnt           number of completed bank swaps (wraps)
module frame_loader #(
    parameter int COLS  = 192,
    parameter int ROWS  = 108,
    parameter int PIX_W = 24,
    parameter int AW    = 15
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [7:0]       s_data,
    input  logic             s_valid,
    input  logic             s_sof,
    output logic             s_ready,
    input  logic             vga_vs,
    input  logic [AW-1:0]    rd_addr,
    output logic [PIX_W-1:0] rd_data,
    output logic             active_bank,
    output logic             frame_done,
    output logic             resync_err,
    output logic [7:0]       frame_cnt
);

    localparam int NPIX = COLS * ROWS;
    localparam int IW   = $clog2(NPIX);

    typedef enum logic [1:0] {
        SYNC,
        LOAD,
        WAIT_SWAP
    } state_t;

    state_t             state_q, state_d;
    logic [1:0]         bph_q, bph_d;
    logic [AW-1:0]      pix_q, pix_d;
    logic [7:0]         r_q, r_d;
    logic [7:0]         g_q, g_d;
    logic               wr_vld_q, wr_vld_d;
    logic [IW-1:0]      wr_addr_q, wr_addr_d;
    logic [PIX_W-1:0]   wr_dat_q, wr_dat_d;
    logic               vs_q, vs_d;
    logic               bank_q, bank_d;
    logic               frame_done_q, frame_done_d;
    logic               resync_err_q, resync_err_d;
    logic [7:0]         frame_cnt_q, frame_cnt_d;
    logic [PIX_W-1:0]   rd_data_q, rd_data_d;

    logic [PIX_W-1:0]   mem0 [NPIX];
    logic [PIX_W-1:0]   mem1 [NPIX];

    logic               accept;
    logic               vs_fall;
    logic               at_start;
    logic               rd_in_range;
    logic [IW-1:0]      rd_idx;

    // Ready depends on registered state only, so it never combinationally follows s_valid.
    assign s_ready  = (state_q != WAIT_SWAP);
    assign accept   = s_valid && s_ready;
    assign vs_fall  = vs_q && !vga_vs;
    assign at_start = (bph_q == 2'd0) && (pix_q == '0);

    assign rd_in_range = (int'(rd_addr) < NPIX);
    assign rd_idx      = rd_addr[IW-1:0];

    always_comb begin
        state_d      = state_q;
        bph_d        = bph_q;
        pix_d        = pix_q;
        r_d          = r_q;
        g_d          = g_q;
        wr_vld_d     = 1'b0;
        wr_addr_d    = wr_addr_q;
        wr_dat_d     = wr_dat_q;
        vs_d         = vga_vs;
        bank_d       = bank_q;
        frame_done_d = 1'b0;
        resync_err_d = 1'b0;
        frame_cnt_d  = frame_cnt_q;

        case (state_q)
            SYNC: begin
                // Everything up to the first start-of-frame byte is thrown away.
                if (accept && s_sof) begin
                    r_d     = s_data;
                    bph_d   = 2'd1;
                    pix_d   = '0;
                    state_d = LOAD;
                end
            end
            LOAD: begin
                if (accept) begin
                    if (s_sof && !at_start) begin
                        // Mid-frame restart: drop the partial frame, this byte is R of pixel 0.
                        resync_err_d = 1'b1;
                        r_d          = s_data;
                        bph_d        = 2'd1;
                        pix_d        = '0;
                    end else begin
                        case (bph_q)
                            2'd0: begin
                                if (at_start && !s_sof) begin
                                    // A new frame must open with s_sof; fall back to discarding.
                                    state_d = SYNC;
                                end else begin
                                    r_d   = s_data;
                                    bph_d = 2'd1;
                                end
                            end
                            2'd1: begin
                                g_d   = s_data;
                                bph_d = 2'd2;
                            end
                            default: begin
                                wr_vld_d  = 1'b1;
                                wr_addr_d = pix_q[IW-1:0];
                                wr_dat_d  = PIX_W'({r_q, g_q, s_data});
                                bph_d     = 2'd0;
                                if (pix_q == AW'(NPIX - 1)) begin
                                    // frame_done lines up with the write of the last pixel.
                                    pix_d        = '0;
                                    frame_done_d = 1'b1;
                                    state_d      = WAIT_SWAP;
                                end else begin
                                    pix_d = pix_q + AW'(1);
                                end
                            end
                        endcase
                    end
                end
            end
            WAIT_SWAP: begin
                if (vs_fall) begin
                    bank_d      = !bank_q;
                    frame_cnt_d = frame_cnt_q + 8'd1;
                    bph_d       = 2'd0;
                    pix_d       = '0;
                    state_d     = LOAD;
                end
            end
            default: state_d = SYNC;
        endcase

        rd_data_d = '0;
        if (rd_in_range) begin
            rd_data_d = bank_q ? mem1[rd_idx] : mem0[rd_idx];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= SYNC;
            bph_q        <= 2'd0;
            pix_q        <= '0;
            r_q          <= '0;
            g_q          <= '0;
            wr_vld_q     <= 1'b0;
            wr_addr_q    <= '0;
            wr_dat_q     <= '0;
            vs_q         <= 1'b1;
            bank_q       <= 1'b0;
            frame_done_q <= 1'b0;
            resync_err_q <= 1'b0;
            frame_cnt_q  <= '0;
            rd_data_q    <= '0;
        end else begin
            state_q      <= state_d;
            bph_q        <= bph_d;
            pix_q        <= pix_d;
            r_q          <= r_d;
            g_q          <= g_d;
            wr_vld_q     <= wr_vld_d;
            wr_addr_q    <= wr_addr_d;
            wr_dat_q     <= wr_dat_d;
            vs_q         <= vs_d;
            bank_q       <= bank_d;
            frame_done_q <= frame_done_d;
            resync_err_q <= resync_err_d;
            frame_cnt_q  <= frame_cnt_d;
            rd_data_q    <= rd_data_d;
        end
    end

    // Pixel storage is not reset. The write uses the bank value of the same edge,
    // so a swap coinciding with the last write still lands the pixel in the old back bank.
    always_ff @(posedge clk) begin
        if (wr_vld_q && !reset) begin
            if (bank_q) begin
                mem0[wr_addr_q] <= wr_dat_q;
            end else begin
                mem1[wr_addr_q] <= wr_dat_q;
            end
        end
    end

    assign rd_data     = rd_data_q;
    assign active_bank = bank_q;
    assign frame_done  = frame_done_q;
    assign resync_err  = resync_err_q;
    assign frame_cnt   = frame_cnt_q;

endmodule

// File: tb/tb_frame_loader.sv
// Bench for frame_loader, run on a reduced 8x4 image so several full frames fit in a short run.
// Reference model: a queue of the bytes of the frame in progress; every third byte completes a pixel.
// Stream bytes are random; pixel contents, pulses and bank state are predicted from the model.
module tb_frame_loader;

    localparam int COLS  = 8;
    localparam int ROWS  = 4;
    localparam int PIX_W = 24;
    localparam int AW    = 6;
    localparam int NPIX  = COLS * ROWS;
    localparam int NBYTE = 3 * NPIX;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic [7:0]       s_data = '0;
    logic             s_valid = 1'b0;
    logic             s_sof = 1'b0;
    logic             s_ready;
    logic             vga_vs = 1'b1;
    logic [AW-1:0]    rd_addr = '0;
    logic [PIX_W-1:0] rd_data;
    logic             active_bank;
    logic             frame_done;
    logic             resync_err;
    logic [7:0]       frame_cnt;

    frame_loader #(.COLS(COLS), .ROWS(ROWS), .PIX_W(PIX_W), .AW(AW)) dut (
        .clk(clk), .reset(reset), .s_data(s_data), .s_valid(s_valid), .s_sof(s_sof),
        .s_ready(s_ready), .vga_vs(vga_vs), .rd_addr(rd_addr), .rd_data(rd_data),
        .active_bank(active_bank), .frame_done(frame_done), .resync_err(resync_err),
        .frame_cnt(frame_cnt)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // ---------------- reference model ----------------
    logic [23:0] m_mem [2][NPIX];
    bit          m_bank;
    int          m_cnt;
    bit          m_wait;
    bit          m_need_sof;
    bit          m_fd, m_re;
    logic [7:0]  m_q [$];

    function void model_reset();
        m_bank = 0; m_cnt = 0; m_wait = 0; m_need_sof = 1;
        m_fd = 0; m_re = 0; m_q.delete();
    endfunction

    function void model_accept(input logic [7:0] d, input bit sof);
        int n;
        m_fd = 0; m_re = 0;
        if (sof) begin
            if (m_q.size() != 0) m_re = 1;
            m_q.delete();
            m_q.push_back(d);
            m_need_sof = 0;
        end else if (m_need_sof) begin
            return;
        end else begin
            m_q.push_back(d);
        end
        n = m_q.size();
        if (n % 3 == 0) begin
            m_mem[!m_bank][n/3 - 1] = {m_q[n-3], m_q[n-2], m_q[n-1]};
            if (n == NBYTE) begin
                m_fd = 1; m_wait = 1; m_q.delete();
            end
        end
    endfunction

    function void model_vs_fall();
        if (m_wait) begin
            m_bank = !m_bank; m_cnt++; m_wait = 0; m_need_sof = 1; m_q.delete();
        end
    endfunction

    // ---------------- stimulus drivers ----------------
    int t_acc, t_fd, t_re, t_fd_pos, t_re_pos;

    task automatic clear_tally();
        t_acc = 0; t_fd = 0; t_re = 0; t_fd_pos = 0; t_re_pos = 0;
    endtask

    task automatic apply_reset();
        reset = 1'b1; s_valid = 1'b0; s_sof = 1'b0; vga_vs = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        model_reset();
    endtask

    // One cycle per byte; pulses are sampled just after the edge that consumed the byte.
    task automatic push(input logic [7:0] d, input bit sof);
        bit acc, exp_acc;
        s_data = d; s_sof = sof; s_valid = 1'b1;
        @(negedge clk);
        acc = s_ready;
        exp_acc = !m_wait;
        @(posedge clk);
        if (exp_acc) model_accept(d, sof);
        else begin m_fd = 0; m_re = 0; end
        #1;
        if (acc) t_acc++;
        if (frame_done === 1'b1) t_fd++;
        if (resync_err === 1'b1) t_re++;
        if (frame_done !== m_fd) t_fd_pos++;
        if (resync_err !== m_re) t_re_pos++;
        s_valid = 1'b0; s_sof = 1'b0;
    endtask

    task automatic stream(input int n, input int sof_a, input int sof_b);
        for (int i = 0; i < n; i++) push(8'($urandom), (i == sof_a) || (i == sof_b));
    endtask

    task automatic do_swap();
        vga_vs = 1'b0;
        @(posedge clk);
        model_vs_fall();
        #1 vga_vs = 1'b1;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Reads every front-bank pixel; returns number of wrong pixels and the first bad address.
    task automatic read_all(output int bad, output int first_bad);
        bad = 0; first_bad = -1;
        for (int a = 0; a < NPIX; a++) begin
            rd_addr = AW'(a);
            @(posedge clk); #1;
            if (rd_data !== m_mem[m_bank][a]) begin
                if (bad == 0) first_bad = a;
                bad++;
            end
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rd_addr = '0;
        apply_reset();
        n_vec++; if (s_ready !== 1'b1) begin n_err++; $display("FAIL reset_s_ready: got %b want 1", s_ready); end
        n_vec++; if (rd_data !== '0) begin n_err++; $display("FAIL reset_rd_data: got %h want 0", rd_data); end
        n_vec++; if (active_bank !== 1'b0) begin n_err++; $display("FAIL reset_bank: got %b want 0", active_bank); end
        n_vec++; if (frame_done !== 1'b0) begin n_err++; $display("FAIL reset_frame_done: got %b want 0", frame_done); end
        n_vec++; if (resync_err !== 1'b0) begin n_err++; $display("FAIL reset_resync_err: got %b want 0", resync_err); end
        n_vec++; if (frame_cnt !== 8'd0) begin n_err++; $display("FAIL reset_frame_cnt: got %0d want 0", frame_cnt); end
    endtask

    task automatic test_full_frame();
        clear_tally();
        stream(NBYTE, 0, -1);
        n_vec++; if (t_acc !== NBYTE) begin n_err++; $display("FAIL full_accepted: got %0d want %0d", t_acc, NBYTE); end
        n_vec++; if (t_fd !== 1 || t_fd_pos !== 0) begin n_err++; $display("FAIL full_frame_done: pulses %0d misplaced %0d want 1/0", t_fd, t_fd_pos); end
        n_vec++; if (t_re !== 0) begin n_err++; $display("FAIL full_resync: got %0d want 0", t_re); end
        @(negedge clk);
        n_vec++; if (s_ready !== 1'b0) begin n_err++; $display("FAIL full_wait_ready: got %b want 0", s_ready); end
        n_vec++; if (active_bank !== 1'b0) begin n_err++; $display("FAIL full_bank: got %b want 0", active_bank); end
        @(posedge clk); #1;
    endtask

    task automatic test_swap();
        int addrs [3];
        addrs = '{0, COLS - 1, NPIX - 1};
        idle(3);
        n_vec++; if (active_bank !== 1'b0) begin n_err++; $display("FAIL swap_early: got %b want 0", active_bank); end
        vga_vs = 1'b0;
        @(negedge clk);
        n_vec++; if (active_bank !== 1'b0) begin n_err++; $display("FAIL swap_before_edge: got %b want 0", active_bank); end
        @(posedge clk);
        model_vs_fall();
        #1 vga_vs = 1'b1;
        n_vec++; if (active_bank !== m_bank) begin n_err++; $display("FAIL swap_bank: got %b want %b", active_bank, m_bank); end
        n_vec++; if (frame_cnt !== 8'(m_cnt)) begin n_err++; $display("FAIL swap_frame_cnt: got %0d want %0d", frame_cnt, m_cnt); end
        @(negedge clk);
        n_vec++; if (s_ready !== 1'b1) begin n_err++; $display("FAIL swap_ready: got %b want 1", s_ready); end
        @(posedge clk); #1;
        foreach (addrs[i]) begin
            rd_addr = AW'(addrs[i]);
            @(posedge clk); #1;
            n_vec++;
            if (rd_data !== m_mem[m_bank][addrs[i]]) begin
                n_err++; $display("FAIL swap_read[%0d]: got %h want %h", addrs[i], rd_data, m_mem[m_bank][addrs[i]]);
            end
        end
    endtask

    task automatic test_no_sof_discard();
        int bad, fb;
        apply_reset();
        clear_tally();
        stream(5, -1, -1);
        n_vec++; if (t_acc !== 5 || t_fd !== 0) begin n_err++; $display("FAIL nosof_accept: acc %0d fd %0d want 5/0", t_acc, t_fd); end
        clear_tally();
        stream(NBYTE, 0, -1);
        n_vec++; if (t_fd !== 1 || t_fd_pos !== 0) begin n_err++; $display("FAIL nosof_frame_done: pulses %0d misplaced %0d want 1/0", t_fd, t_fd_pos); end
        do_swap();
        read_all(bad, fb);
        n_vec++; if (bad !== 0) begin n_err++; $display("FAIL nosof_pixels: %0d wrong, first at %0d, want 0 wrong", bad, fb); end
    endtask

    task automatic test_resync();
        int bad, fb;
        clear_tally();
        stream(2, -1, -1);          // no s_sof at the start of a new frame: dropped
        stream(40, 0, -1);          // partial frame
        stream(NBYTE, 0, -1);       // s_sof mid-frame restarts it
        n_vec++; if (t_re !== 1 || t_re_pos !== 0) begin n_err++; $display("FAIL resync_pulse: pulses %0d misplaced %0d want 1/0", t_re, t_re_pos); end
        n_vec++; if (t_fd !== 1 || t_fd_pos !== 0) begin n_err++; $display("FAIL resync_frame_done: pulses %0d misplaced %0d want 1/0", t_fd, t_fd_pos); end
        do_swap();
        clear_tally();
        stream(NBYTE, 0, NBYTE - 1); // s_sof on the last byte: restart, no frame_done
        n_vec++; if (t_re !== 1 || t_fd !== 0 || t_re_pos !== 0 || t_fd_pos !== 0) begin
            n_err++; $display("FAIL resync_last: re %0d fd %0d misplaced %0d/%0d want 1/0/0/0", t_re, t_fd, t_re_pos, t_fd_pos);
        end
        stream(NBYTE - 1, -1, -1);
        n_vec++; if (t_fd !== 1 || t_fd_pos !== 0) begin n_err++; $display("FAIL resync_last_done: pulses %0d misplaced %0d want 1/0", t_fd, t_fd_pos); end
        do_swap();
        read_all(bad, fb);
        n_vec++; if (bad !== 0) begin n_err++; $display("FAIL resync_pixels: %0d wrong, first at %0d, want 0 wrong", bad, fb); end
    endtask

    task automatic test_wait_hold();
        int bad, fb;
        bit bank0;
        clear_tally();
        stream(NBYTE, 0, -1);
        clear_tally();
        bank0 = m_bank;
        stream(100, -1, -1);
        n_vec++; if (t_acc !== 0) begin n_err++; $display("FAIL hold_ready: accepted %0d want 0", t_acc); end
        n_vec++; if (active_bank !== bank0) begin n_err++; $display("FAIL hold_bank: got %b want %b", active_bank, bank0); end
        do_swap();
        read_all(bad, fb);
        n_vec++; if (bad !== 0) begin n_err++; $display("FAIL hold_pixels: %0d wrong, first at %0d, want 0 wrong", bad, fb); end
        // vsync edge during LOAD is ignored and does not arm a later swap
        clear_tally();
        stream(20, 0, -1);
        do_swap();
        idle(1);
        n_vec++; if (active_bank !== m_bank || frame_cnt !== 8'(m_cnt)) begin
            n_err++; $display("FAIL load_vs: bank %b cnt %0d want %b %0d", active_bank, frame_cnt, m_bank, m_cnt);
        end
        stream(NBYTE - 20, -1, -1);
        idle(3);
        n_vec++; if (t_fd !== 1 || active_bank !== m_bank) begin
            n_err++; $display("FAIL load_vs_after: fd %0d bank %b want 1 %b", t_fd, active_bank, m_bank);
        end
    endtask

    task automatic test_oob_read();
        rd_addr = AW'(NPIX);
        @(posedge clk); #1;
        n_vec++; if (rd_data !== '0) begin n_err++; $display("FAIL oob_read_npix: got %h want 0", rd_data); end
        rd_addr = '1;
        @(posedge clk); #1;
        n_vec++; if (rd_data !== '0) begin n_err++; $display("FAIL oob_read_max: got %h want 0", rd_data); end
    endtask

    task automatic test_reset_in_wait();
        @(negedge clk);
        n_vec++; if (s_ready !== 1'b0) begin n_err++; $display("FAIL rstwait_pre_ready: got %b want 0", s_ready); end
        apply_reset();
        n_vec++; if (active_bank !== 1'b0 || frame_cnt !== 8'd0 || s_ready !== 1'b1) begin
            n_err++; $display("FAIL rstwait_state: bank %b cnt %0d ready %b want 0 0 1", active_bank, frame_cnt, s_ready);
        end
        do_swap();
        idle(1);
        n_vec++; if (active_bank !== m_bank || frame_cnt !== 8'(m_cnt)) begin
            n_err++; $display("FAIL rstwait_no_swap: bank %b cnt %0d want %b %0d", active_bank, frame_cnt, m_bank, m_cnt);
        end
    endtask

    initial begin
        test_reset();
        test_full_frame();
        test_swap();
        test_no_sof_discard();
        test_resync();
        test_wait_hold();
        test_oob_read();
        test_reset_in_wait();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, %0d vectors, %0d miscompares", n_vec, n_err);
        $fatal(1, "timeout");
    end

endmodule
